fifo_flops_ext: RTL and testbench
=================================

// Module: fifo_flops_ext
// PURPOSE
//  Parametrised, flop-based synchronous FIFO; next generation of fifo_flops.
//  Adds any (non-power-of-2) depth, occupancy count, almost-full/almost-empty
//  thresholds, sticky overflow/underflow flags and a selectable full-policy
//  (drop-new or overwrite-oldest). Sits between driver-side producers and DUT
//  consumers; drop-in superset of the fifo_flops port set.
// PARAMETERS
//  bits   16  data width in bits (>=1)
//  depth  8   number of entries (>=2, any integer)
//  af_lvl 6   almost_full asserted when count >= af_lvl (1..depth)
//  ae_lvl 1   almost_empty asserted when count <= ae_lvl (0..depth-1)
//  mode   0   full-policy: 0 = FIFO_DROP_NEW, 1 = FIFO_OVERWRITE (fifo_pkg)
// PORTS
//  clk          in   1           rising-edge clock
//  rst          in   1           asynchronous, active-high reset
//  Din          in   bits        write data, sampled with push
//  push         in   1           write request
//  pop          in   1           read request (consumes head)
//  clr_err      in   1           synchronous clear of sticky error flags
//  Dout         out  bits        head entry (show-ahead); 0 when empty
//  pndng        out  1           FIFO non-empty
//  full         out  1           count == depth
//  almost_full  out  1           count >= af_lvl
//  almost_empty out  1           count <= ae_lvl
//  count        out  CW          occupancy, CW = $clog2(depth+1)
//  overflow     out  1           sticky: a push was dropped or overwrote data
//  underflow    out  1           sticky: pop issued while empty
// BEHAVIOUR
//  - Reset (async, rst=1): rd_ptr=wr_ptr=0, count=0, pndng=0, full=0,
//    almost_empty=1 (ae_lvl>=0), almost_full=0, overflow=0, underflow=0, Dout=0.
//    Memory contents are not reset. Reset mid-operation discards all data.
//  - All state updates on posedge clk; flags/count/Dout are derived from
//    registered state, so a push is visible on Dout/pndng one cycle later.
//  - Pointers wrap explicitly: ptr == depth-1 -> 0 (no modulo-2^n trick).
//  - Not full, push: write Din at wr_ptr, wr_ptr++, count++.
//  - Not empty, pop: rd_ptr++, count--. Dout shows the new head next cycle.
//  - Empty, pop (no push): no state change, underflow<=1.
//  - Empty, push+pop: push accepted, pop ignored, underflow<=1, count=1.
//  - Not empty/not full, push+pop: both accepted, count unchanged.
//  - Full, push+pop: both accepted (pop frees slot same cycle), count=depth,
//    no overflow.
//  - Full, push only, mode=DROP_NEW: Din discarded, state unchanged,
//    overflow<=1.
//  - Full, push only, mode=OVERWRITE: write at wr_ptr (== rd_ptr), both
//    pointers ++, count stays depth, oldest entry lost, overflow<=1.
//  - clr_err=1 clears overflow/underflow; a new error in the same cycle wins
//    (flag stays 1).
//  - count arithmetic in CW bits; never exceeds depth, never below 0.
// STRUCTURE
//  - fifo_pkg: typedef enum logic {FIFO_DROP_NEW, FIFO_OVERWRITE} fifo_mode_e;
//    function fifo_cw(depth) returning $clog2(depth+1).
//  - Sub-module fifo_mem_flops: depth x bits flop array, one write port
//    (we, waddr, wdata), one combinational read port (raddr -> rdata).
//  - Top holds pointers, count, flag and error logic; elaboration-time
//    assertions check parameter ranges.
// TESTING (bits=16, depth=8, af_lvl=6, ae_lvl=1 unless stated)
//  1 Reset, push 0x0001..0x0008 -> full=1 after 8th, count=8, almost_full from
//    count 6; pop x8 -> Dout 0x0001..0x0008 in order, pndng=0, almost_empty=1.
//  2 Fill 8, push 0xBEEF (mode=0) -> overflow=1, count=8, pops return
//    0x0001..0x0008; clr_err -> overflow=0.
//  3 mode=1: fill 8, push 0xBEEF -> overflow=1, count=8, first pop 0x0002,
//    last pop 0xBEEF.
//  4 Empty: pop -> underflow=1, count=0; push 0x00AA+pop same cycle ->
//    count=1, Dout=0x00AA.
//  5 depth=5: 20 cycles of push+pop with incrementing data after 3 preloads
//    -> count stays 3, pointer wrap verified, data order preserved.
//  6 Fill 4 entries, assert rst mid-cycle (async) -> count=0, pndng=0, flags
//    clear immediately without waiting for clk.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flop-based FIFO family.
package fifo_pkg;

    typedef enum logic {
        FIFO_DROP_NEW  = 1'b0,
        FIFO_OVERWRITE = 1'b1
    } fifo_mode_e;

    function automatic int fifo_cw(input int d);
        return $clog2(d + 1);
    endfunction

    function automatic int fifo_aw(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem_flops.sv
// Flop array storage: one synchronous write port, one combinational read port.
module fifo_mem_flops #(
    parameter int bits  = 16,
    parameter int depth = 8,
    parameter int aw    = 3
) (
    input  logic            clk,
    input  logic            we,
    input  logic [aw-1:0]   waddr,
    input  logic [bits-1:0] wdata,
    input  logic [aw-1:0]   raddr,
    output logic [bits-1:0] rdata
);

    logic [bits-1:0] mem [depth];

    // Contents are deliberately not reset; occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flops_ext.sv
// Flop-based synchronous FIFO with any depth, occupancy, thresholds,
// sticky error flags and a selectable full-policy.
module fifo_flops_ext
    import fifo_pkg::*;
#(
    parameter int         bits   = 16,
    parameter int         depth  = 8,
    parameter int         af_lvl = 6,
    parameter int         ae_lvl = 1,
    parameter fifo_mode_e mode   = FIFO_DROP_NEW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [bits-1:0]            Din,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr_err,
    output logic [bits-1:0]            Dout,
    output logic                       pndng,
    output logic                       full,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [fifo_cw(depth)-1:0]  count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = fifo_cw(depth);
    localparam int AW = fifo_aw(depth);

    localparam logic [CW-1:0] CNT_MAX = CW'(depth);
    localparam logic [CW-1:0] AF_CNT  = CW'(af_lvl);
    localparam logic [CW-1:0] AE_CNT  = CW'(ae_lvl);
    localparam logic [AW-1:0] PTR_MAX = AW'(depth - 1);

    if (bits < 1) begin : g_bad_bits
        $error("fifo_flops_ext: bits must be >= 1");
    end
    if (depth < 2) begin : g_bad_depth
        $error("fifo_flops_ext: depth must be >= 2");
    end
    if (af_lvl < 1 || af_lvl > depth) begin : g_bad_af
        $error("fifo_flops_ext: af_lvl must be in 1..depth");
    end
    if (ae_lvl < 0 || ae_lvl > depth - 1) begin : g_bad_ae
        $error("fifo_flops_ext: ae_lvl must be in 0..depth-1");
    end

    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;
    logic [bits-1:0] rdata;

    logic is_empty;
    logic is_full;
    logic do_push;
    logic do_pop;
    logic ovw;
    logic adv_rd;
    logic ov_evt;
    logic un_evt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + AW'(1);
    endfunction

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_MAX);

    // Full with a simultaneous pop always frees a slot this cycle.
    assign do_pop  = pop && !is_empty;
    assign ovw     = push && is_full && !pop && (mode == FIFO_OVERWRITE);
    assign do_push = push && (!is_full || pop || ovw);
    assign adv_rd  = do_pop || ovw;

    assign ov_evt = push && is_full && !pop;
    assign un_evt = pop && is_empty;

    fifo_mem_flops #(
        .bits  (bits),
        .depth (depth),
        .aw    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (Din),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (adv_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !adv_rd) begin
                cnt <= cnt + CW'(1);
            end else if (adv_rd && !do_push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // A fresh error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ov_evt || (overflow && !clr_err);
            underflow <= un_evt || (underflow && !clr_err);
        end
    end

    assign Dout         = is_empty ? '0 : rdata;
    assign pndng        = !is_empty;
    assign full         = is_full;
    assign almost_full  = (cnt >= AF_CNT);
    assign almost_empty = (cnt <= AE_CNT);
    assign count        = cnt;

endmodule

// File: tb/tb_fifo_flops_ext.sv
// Randomised and directed checks of fifo_flops_ext against a queue model.
module tb_fifo_flops_ext;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] din_i   [3];
    logic        push_i  [3];
    logic        pop_i   [3];
    logic        clr_i   [3];
    logic [15:0] dout_o  [3];
    logic        pndng_o [3];
    logic        full_o  [3];
    logic        af_o    [3];
    logic        ae_o    [3];
    logic        ov_o    [3];
    logic        un_o    [3];
    logic [3:0]  cnt_a;
    logic [3:0]  cnt_b;
    logic [2:0]  cnt_c;

    int dep [3];
    int afl [3];
    int ael [3];
    bit ovm [3];

    logic [15:0] mq [3][$];
    bit          m_ov [3];
    bit          m_un [3];

    int checks   = 0;
    int failures = 0;

    fifo_flops_ext #(
        .bits(16), .depth(8), .af_lvl(6), .ae_lvl(1), .mode(FIFO_DROP_NEW)
    ) u_drop (
        .clk(clk), .rst(rst), .Din(din_i[0]), .push(push_i[0]),
        .pop(pop_i[0]), .clr_err(clr_i[0]), .Dout(dout_o[0]),
        .pndng(pndng_o[0]), .full(full_o[0]), .almost_full(af_o[0]),
        .almost_empty(ae_o[0]), .count(cnt_a), .overflow(ov_o[0]),
        .underflow(un_o[0])
    );

    fifo_flops_ext #(
        .bits(16), .depth(8), .af_lvl(6), .ae_lvl(1), .mode(FIFO_OVERWRITE)
    ) u_ovw (
        .clk(clk), .rst(rst), .Din(din_i[1]), .push(push_i[1]),
        .pop(pop_i[1]), .clr_err(clr_i[1]), .Dout(dout_o[1]),
        .pndng(pndng_o[1]), .full(full_o[1]), .almost_full(af_o[1]),
        .almost_empty(ae_o[1]), .count(cnt_b), .overflow(ov_o[1]),
        .underflow(un_o[1])
    );

    fifo_flops_ext #(
        .bits(16), .depth(5), .af_lvl(4), .ae_lvl(1), .mode(FIFO_DROP_NEW)
    ) u_d5 (
        .clk(clk), .rst(rst), .Din(din_i[2]), .push(push_i[2]),
        .pop(pop_i[2]), .clr_err(clr_i[2]), .Dout(dout_o[2]),
        .pndng(pndng_o[2]), .full(full_o[2]), .almost_full(af_o[2]),
        .almost_empty(ae_o[2]), .count(cnt_c), .overflow(ov_o[2]),
        .underflow(un_o[2])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int k);
        case (k)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    // Queue-level behaviour: what an ideal FIFO of each policy would hold.
    task automatic model_step(input int k);
        int  n;
        bit  e;
        bit  f;
        n = mq[k].size();
        e = (n == 0);
        f = (n == dep[k]);
        if (e) begin
            if (push_i[k]) mq[k].push_back(din_i[k]);
        end else if (f && push_i[k] && !pop_i[k]) begin
            if (ovm[k]) begin
                void'(mq[k].pop_front());
                mq[k].push_back(din_i[k]);
            end
        end else begin
            if (pop_i[k]) void'(mq[k].pop_front());
            if (push_i[k]) mq[k].push_back(din_i[k]);
        end
        m_ov[k] = (push_i[k] && f && !pop_i[k]) ? 1'b1 : (m_ov[k] && !clr_i[k]);
        m_un[k] = (pop_i[k] && e) ? 1'b1 : (m_un[k] && !clr_i[k]);
    endtask

    task automatic check_all(input int k);
        int n;
        n = mq[k].size();
        chk($sformatf("k%0d_count", k), cnt_of(k), n);
        chk($sformatf("k%0d_dout", k), dout_o[k], (n != 0) ? mq[k][0] : 16'h0);
        chk($sformatf("k%0d_pndng", k), pndng_o[k], n != 0);
        chk($sformatf("k%0d_full", k), full_o[k], n == dep[k]);
        chk($sformatf("k%0d_afull", k), af_o[k], n >= afl[k]);
        chk($sformatf("k%0d_aempty", k), ae_o[k], n <= ael[k]);
        chk($sformatf("k%0d_ovf", k), ov_o[k], m_ov[k]);
        chk($sformatf("k%0d_unf", k), un_o[k], m_un[k]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            m_ov[k] = 1'b0;
            m_un[k] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        for (int k = 0; k < 3; k++) check_all(k);
        for (int k = 0; k < 3; k++) begin
            push_i[k] = 1'b0;
            pop_i[k]  = 1'b0;
            clr_i[k]  = 1'b0;
        end
    endtask

    task automatic op(input int k, input bit pu, input bit po,
                      input logic [15:0] d, input bit cl);
        push_i[k] = pu;
        pop_i[k]  = po;
        din_i[k]  = d;
        clr_i[k]  = cl;
        step();
    endtask

    initial begin
        dep = '{8, 8, 5};
        afl = '{6, 6, 4};
        ael = '{1, 1, 1};
        ovm = '{1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            din_i[k]  = '0;
            push_i[k] = 1'b0;
            pop_i[k]  = 1'b0;
            clr_i[k]  = 1'b0;
        end
        model_reset();
        #12;
        for (int k = 0; k < 3; k++) check_all(k);
        chk("rst_aempty", ae_o[0], 1'b1);
        chk("rst_dout", dout_o[0], 16'h0);
        rst = 1'b0;

        // fill and drain in order
        for (int i = 1; i <= 8; i++) begin
            op(0, 1, 0, 16'(i), 0);
            chk("t1_afull", af_o[0], i >= 6);
        end
        chk("t1_full", full_o[0], 1'b1);
        chk("t1_count", cnt_a, 4'd8);
        for (int i = 1; i <= 8; i++) begin
            chk("t1_head", dout_o[0], 16'(i));
            op(0, 0, 1, 16'h0, 0);
        end
        chk("t1_pndng", pndng_o[0], 1'b0);
        chk("t1_aempty", ae_o[0], 1'b1);

        // drop-new on full
        for (int i = 1; i <= 8; i++) op(0, 1, 0, 16'(i), 0);
        op(0, 1, 0, 16'hBEEF, 0);
        chk("t2_ovf", ov_o[0], 1'b1);
        chk("t2_count", cnt_a, 4'd8);
        for (int i = 1; i <= 8; i++) begin
            chk("t2_head", dout_o[0], 16'(i));
            op(0, 0, 1, 16'h0, 0);
        end
        op(0, 0, 0, 16'h0, 1);
        chk("t2_clr", ov_o[0], 1'b0);

        // overwrite-oldest on full
        for (int i = 1; i <= 8; i++) op(1, 1, 0, 16'(i), 0);
        op(1, 1, 0, 16'hBEEF, 0);
        chk("t3_ovf", ov_o[1], 1'b1);
        chk("t3_count", cnt_b, 4'd8);
        chk("t3_first", dout_o[1], 16'h0002);
        for (int i = 0; i < 7; i++) op(1, 0, 1, 16'h0, 0);
        chk("t3_last", dout_o[1], 16'hBEEF);
        op(1, 0, 1, 16'h0, 1);

        // underflow and push+pop on empty
        op(0, 0, 1, 16'h0, 0);
        chk("t4_unf", un_o[0], 1'b1);
        chk("t4_count0", cnt_a, 4'd0);
        op(0, 1, 1, 16'h00AA, 0);
        chk("t4_count1", cnt_a, 4'd1);
        chk("t4_dout", dout_o[0], 16'h00AA);
        op(0, 0, 1, 16'h0, 1);
        chk("t4_clr", un_o[0], 1'b0);

        // depth 5 steady-state wrap
        for (int i = 0; i < 3; i++) op(2, 1, 0, 16'(16'h100 + i), 0);
        for (int i = 3; i < 23; i++) begin
            op(2, 1, 1, 16'(16'h100 + i), 0);
            chk("t5_count", cnt_c, 3'd3);
            chk("t5_head", dout_o[2], 16'(16'h100 + i - 2));
        end
        for (int i = 0; i < 3; i++) op(2, 0, 1, 16'h0, 0);

        // random traffic, alternating fill- and drain-biased phases
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 40) % 2 == 0) ? 80 : 25;
            for (int k = 0; k < 3; k++) begin
                push_i[k] = ($urandom_range(99) < bias);
                pop_i[k]  = ($urandom_range(99) < 100 - bias);
                din_i[k]  = 16'($urandom);
                clr_i[k]  = ($urandom_range(15) == 0);
            end
            step();
        end

        // async reset between clock edges
        for (int k = 0; k < 3; k++) begin
            while (mq[k].size() > 0) op(k, 0, 1, 16'h0, 0);
        end
        for (int i = 0; i < 4; i++) op(0, 1, 0, 16'(16'h40 + i), 0);
        op(0, 0, 1, 16'h0, 0);
        op(0, 0, 1, 16'h0, 0);
        op(0, 0, 1, 16'h0, 0);
        op(0, 0, 1, 16'h0, 0);
        op(0, 0, 1, 16'h0, 0);
        for (int i = 0; i < 4; i++) op(0, 1, 0, 16'(16'h50 + i), 0);
        chk("t6_pre", cnt_a, 4'd4);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6_count", cnt_a, 4'd0);
        chk("t6_pndng", pndng_o[0], 1'b0);
        chk("t6_unf", un_o[0], 1'b0);
        for (int k = 0; k < 3; k++) check_all(k);
        #1;
        rst = 1'b0;
        op(0, 1, 0, 16'h1234, 0);
        chk("t6_after", dout_o[0], 16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
